iter_divider: RTL and testbench
===============================

# iter_divider

Multi-cycle restoring integer divider, one quotient bit per clock. It is the inverse-operation companion to the pipelined multiplier datapath. A start/done handshake connects it to the execute stage, which stalls while `busy` is high. It also provides quotient, remainder and a divide-by-zero flag.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥ 2).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when the block is ready (see Operation).
- `dividend`  in  WIDTH  sampled on the accepting edge only.
- `divisor`  in  WIDTH  sampled on the accepting edge only.
- `is_signed`  in  1  present only with `DIV_SIGNED_EN`; sampled with the operands.
- `busy`  out  1  high while the iteration is running.
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  WIDTH  result, held until the next accepted start or reset.
- `remainder`  out  WIDTH  result, held likewise.
- `div_by_zero`  out  1  set with `done` when divisor == 0; held with the results.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, iteration counter=0.
- Ready means the state is IDLE or DONE. In that state, `start`=1 latches the operands, which allows back-to-back operations.
- `start` while in RUN is ignored. The operation in flight and its operands are unaffected.
- Accept with divisor ≠ 0:
  - State goes to RUN.
  - Working remainder clears to 0.
  - The dividend magnitude loads into the shift register.
  - Counter clears.
- RUN, each edge:
  - Shift {rem, q} left by one.
  - Trial = rem − divisor magnitude, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and the new quotient LSB = 1. Otherwise rem is unchanged and the LSB = 0.
  - Counter increments.
  - On the WIDTH-th RUN edge: registered outputs are written, state goes to DONE, and `div_by_zero`=0.
- Accept with divisor == 0: skip RUN. Go straight to DONE with `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
- DONE lasts one cycle (`done`=1), then IDLE unless a new start is accepted.
- Unsigned results satisfy dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Accept edge N (divisor ≠ 0):
  - `busy`=1 during cycles after edges N … N+WIDTH−1.
  - Outputs update at edge N+WIDTH.
  - `done`=1 for exactly the cycle following edge N+WIDTH.
  - Latency = WIDTH cycles.
- Divide by zero: outputs update at edge N, `done`=1 the following cycle, `busy` never asserts. Latency 1.
- `busy` and `done` are never high in the same cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `rst` mid-RUN: at the next edge the state goes to IDLE, all outputs go to reset values, no `done` is produced, and the partial result is discarded.
- `rst` and `start` in the same cycle: reset wins and the request is dropped.
- The requester must hold `start` until it observes the accept (`busy` rising or `done`). A `start` held high through DONE immediately begins a new operation with the current operands.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- Defined:
  - The `is_signed` port exists.
  - With `is_signed`=1, operands are converted to magnitudes at accept.
  - Quotient is negated when the operand signs differ, truncating toward zero.
  - Remainder takes the sign of the dividend.
  - Sign fixup is applied while writing the output registers, so latency is unchanged.
  - −2^(WIDTH−1) / −1 yields `quotient`=−2^(WIDTH−1) (wrap) and `remainder`=0.
  - Divide by zero returns the same values as the unsigned case.
- Undefined: the port is absent, division is unsigned only, and no sign logic is synthesized.

## Test plan
- 100 / 7, unsigned, WIDTH=32 → after 32 cycles `done`=1, `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high exactly 32 cycles.
- 0xFFFFFFFF / 1, then back-to-back 5 / 9 via `start` held through DONE → first result q=0xFFFFFFFF r=0. Second result q=0 r=5, with `done` 33 cycles after the first `done`.
- 1234 / 0 → `done` on the cycle after accept, q=0xFFFFFFFF, r=1234, `div_by_zero`=1, `busy` never high.
- Start 50 / 3, pulse `start` with 9 / 9 at cycle 10 of RUN → ignored; result q=16 r=2 at cycle 32.
- Start 77 / 5, assert `rst` at cycle 12 → all outputs 0, no `done` for 40 cycles. A new start of 77 / 5 then returns q=15 r=2.
- With `DIV_SIGNED_EN`:
  - −7 / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF signed → q=0x80000000, r=0.
  - Same operands with `is_signed`=0 → q=0, r=0x80000000.

Source files
------------

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider producing one quotient bit per clock, with a start/done handshake.
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds the is_signed port).
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_step, q_step;
  logic [WIDTH-1:0] quot_final, rem_final;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic dvd_neg, dvs_neg;

  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor  : divisor;
  end

  assign quot_final = neg_q_q ? -q_step   : q_step;
  assign rem_final  = neg_r_q ? -rem_step : rem_step;
`else
  assign dvd_mag    = dividend;
  assign dvs_mag    = divisor;
  assign quot_final = q_step;
  assign rem_final  = rem_step;
`endif

  // One restoring step: shift {rem, q} left, subtract at WIDTH+1 bits, keep if non-negative.
  always_comb begin
    shifted = {rem_q, shreg_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      q_step   = {shreg_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shifted[WIDTH-1:0];
      q_step   = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
`endif
    case (state_q)
      RUN: begin
        rem_d   = rem_step;
        shreg_d = q_step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d    = DONE;
          quot_out_d = quot_final;
          rem_out_d  = rem_final;
          dbz_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d    = DONE;
            quot_out_d = '1;
            rem_out_d  = dividend;
            dbz_d      = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            shreg_d = dvd_mag;
            dvsr_d  = dvs_mag;
            cnt_d   = '0;
`ifdef DIV_SIGNED_EN
            neg_q_d = dvd_neg ^ dvs_neg;
            neg_r_d = dvd_neg;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      shreg_q    <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected results, a monitor pops on done.
module tb_iter_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         is_signed = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  iter_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done with q=%h r=%h, required no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z || busy !== 1'b0) begin
          fails++;
          $display("FAIL result: got q=%h r=%h dbz=%b busy=%b, required q=%h r=%h dbz=%b busy=0",
                   quotient, remainder, div_by_zero, busy, e.q, e.r, e.z);
        end else begin
          $display("[TB] done q=%h r=%h dbz=%b ok", quotient, remainder, div_by_zero);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input bit hold, input bit push);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (push) sb.push_back('{eq, er, ez});
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts cycles after the accept edge until done; optionally pulses start mid-run.
  task automatic wait_done(input int exp_n, input int exp_busy, input int glitch_at, input string name);
    int  n = 0;
    int  busy_cnt = 0;
    bit  found = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      n = i;
      if (busy) busy_cnt++;
      if (done) found = 1;
      if (glitch_at > 0 && i == glitch_at) begin
        start = 1'b1; dividend = 9; divisor = 9;
      end
      if (glitch_at > 0 && i == glitch_at + 1) start = 1'b0;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s_timeout: got no done in 200 cycles, required done at cycle %0d", name, exp_n);
    end else begin
      chk({name, "_latency"}, W'(n), W'(exp_n));
      chk({name, "_busy_cycles"}, W'(busy_cnt), W'(exp_busy));
    end
  endtask

  initial begin
    int done_seen;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_q", quotient, '0);
    chk("reset_r", remainder, '0);
    chk("reset_dbz", W'(div_by_zero), '0);
    rst = 1'b0;

    issue(100, 7, 0, 14, 2, 0, 0, 1);
    wait_done(W + 1, W, 0, "100_by_7");

    issue(32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 1);
    dividend = 5;
    divisor  = 9;
    sb.push_back('{32'd0, 32'd5, 1'b0});
    wait_done(W + 1, W, 0, "max_by_1");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(W + 1, W, 0, "b2b_5_by_9");

    issue(1234, 0, 0, 32'hFFFF_FFFF, 1234, 1, 0, 1);
    wait_done(1, 0, 0, "div_zero");

    issue(50, 3, 0, 16, 2, 0, 0, 1);
    wait_done(W + 1, W, 10, "ignore_start");

    issue(1000, 1000, 0, 1, 0, 0, 0, 1);
    wait_done(W + 1, W, 0, "equal");
    issue(3, 7, 0, 0, 3, 0, 0, 1);
    wait_done(W + 1, W, 0, "small_by_big");

    issue(77, 5, 0, 0, 0, 0, 0, 0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_busy", W'(busy), '0);
    chk("midrun_rst_q", quotient, '0);
    chk("midrun_rst_r", remainder, '0);
    chk("midrun_rst_dbz", W'(div_by_zero), '0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrun_rst_no_done", W'(done_seen), '0);
    issue(77, 5, 0, 15, 2, 0, 0, 1);
    wait_done(W + 1, W, 0, "77_by_5");

`ifdef DIV_SIGNED_EN
    issue(-32'sd7, 2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 1);
    wait_done(W + 1, W, 0, "s_m7_by_2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0, 0, 1);
    wait_done(W + 1, W, 0, "s_min_by_m1");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 0, 0, 1);
    wait_done(W + 1, W, 0, "u_min_by_max");
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
